core_req_arbiter: RTL and testbench
===================================

// Module: core_req_arbiter
// PURPOSE
//  Shares one processing core (top_level_4_260: clk/reset/data_in/data_out) between N requesters.
//  Round-robin grants one request at a time and drives the core's data_in with a one-cycle start pulse.
//  Waits for core_done, then returns data_out to the owning requester over a valid/ready response.
//  Sits between bench/host agents and the core; one transaction in flight.
// PARAMETERS
//  N_REQ      4    number of requesters (2..8)
//  DW         8    data width of core data_in/data_out
//  TIMEOUT    255  max cycles in WAIT before abort (used only with CORE_ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1         single clock, rising edge
//  reset          in   1         asynchronous, active-low (0 = reset)
//  req_valid      in   N_REQ     per-requester request valid
//  req_data       in   N_REQ*DW  request payloads, requester i at [i*DW +: DW]
//  req_ready      out  N_REQ     one-hot accept strobe
//  rsp_valid      out  N_REQ     one-hot response valid, to the owner only
//  rsp_ready      in   N_REQ     per-requester response ready
//  rsp_data       out  DW        response payload (shared bus)
//  rsp_err        out  1         response is a timeout abort (tied 0 without macro)
//  core_data_in   out  DW        to core data_in
//  core_start     out  1         one-cycle start pulse to core
//  core_done      in   1         core result valid on core_data_out
//  core_data_out  in   DW        from core data_out
// BEHAVIOUR
//  Reset (async assert): state=IDLE; req_ready, rsp_valid, rsp_data, rsp_err, core_data_in, core_start all 0.
//  Reset also sets last_grant=N_REQ-1, so requester 0 has top priority after reset.
//  Reset mid-transaction abandons it silently; no response is issued.
//  FSM states are IDLE, ISSUE, WAIT and RESP.
//  IDLE
//   - grant = first valid requester scanning last_grant+1 .. last_grant (wraps modulo N_REQ).
//   - req_ready[grant] asserted combinationally in the same cycle; no grant -> req_ready all 0.
//   - On the accepting edge: latch req_data[grant] and owner=grant, go to ISSUE.
//  ISSUE
//   - core_data_in = latched data (held stable through WAIT); core_start=1 for exactly this cycle.
//   - Go to WAIT.
//  WAIT
//   - core_done is sampled only in this state; core_done in IDLE, ISSUE or RESP is ignored.
//   - On core_done: capture core_data_out into rsp_data, go to RESP.
//  RESP
//   - rsp_valid[owner]=1; rsp_data and rsp_err held stable until rsp_ready[owner].
//   - Other rsp_ready bits are ignored.
//   - On handshake: last_grant=owner, go to IDLE.
//  Latency: accept->start is 1 cycle; done->rsp_valid is 1 cycle.
//  Minimum period is 4 cycles per transaction (core done in the first WAIT cycle, rsp_ready high).
//  Requesters must hold req_valid/req_data until req_ready; the grant is re-evaluated every IDLE cycle.
//  Simultaneous requests: exactly one is granted per transaction; others wait, and rotation guarantees no starvation.
//  Priority does not advance on a timeout-aborted transaction? No: it advances on every completed RESP handshake, including aborts.
// CONFIGURATION
//  Macro CORE_ARB_TIMEOUT_EN
//  - Defined: an 8-bit+ counter clears on entering WAIT and increments each WAIT cycle.
//    - If it reaches TIMEOUT without core_done: go to RESP with rsp_err=1 and rsp_data=0.
//    - core_done in the same cycle as the timeout wins (normal response, rsp_err=0).
//  - Undefined: WAIT waits indefinitely; rsp_err is constant 0; no counter is synthesized.
// STRUCTURE
//  Package core_arb_pkg: state_t enum {IDLE,ISSUE,WAIT,RESP}; localparam for the counter width.
//  Sub-module rr_arbiter #(N_REQ) (req, last_grant -> onehot grant, grant_idx, any).
//  rr_arbiter is purely combinational and reusable elsewhere.
// TESTING
//  1. Single request: req_valid=0001, data 8'h5A; core_done 3 cycles after start with data_out 8'hA5
//     -> start 1 cycle after accept; rsp_valid=0001 with rsp_data=8'hA5.
//  2. All four requesting continuously after reset -> grant order 0,1,2,3,0; exactly one start pulse per transaction.
//  3. Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable; no new req_ready asserted until handshake.
//  4. Async reset asserted in WAIT -> outputs 0 immediately; next grant goes to requester 0; stale core_done ignored.
//  5. Spurious core_done in IDLE/ISSUE -> no response issued; FSM state unchanged.
//  6. (CORE_ARB_TIMEOUT_EN, TIMEOUT=10) core never done -> rsp_err=1, rsp_data=0 after 10 WAIT cycles; priority rotates.

Source files
------------

// File: rtl/core_arb_pkg.sv
// Shared types for the core request arbiter: FSM state encoding, the WAIT
// timeout counter width and a small round-robin index helper.
package core_arb_pkg;

    // Transaction phases: pick a requester, pulse the core, wait, respond.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Width of the WAIT-cycle counter; must hold TIMEOUT-1 (TIMEOUT <= 255).
    localparam int TMR_W = 8;

    // Index reached by stepping 'step' places past 'base' on a ring of 'n'.
    function automatic int rr_index(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Scans requesters starting just after
// last_grant and wrapping, returning the first active one as a one-hot vector
// and as an index. 'any' is low (and grant all zero) when nobody requests.
module rr_arbiter
    import core_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int idx;

    // First active requester after last_grant wins; last_grant itself is checked last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = rr_index(int'(last_grant), k, N_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/core_req_arbiter.sv
// Shares one processing core between N_REQ requesters. One transaction is in
// flight at a time: accept a request (round-robin), pulse core_start with the
// latched payload, wait for core_done, then hand core_data_out back to the
// owning requester over a valid/ready response.
// Optional feature: define CORE_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT
// cycles with rsp_err=1 and rsp_data=0. Without it WAIT is unbounded and
// rsp_err is tied low.
module core_req_arbiter
    import core_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_err,
    output logic [DW-1:0]       core_data_in,
    output logic                core_start,
    input  logic                core_done,
    input  logic [DW-1:0]       core_data_out
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] owner;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic [DW-1:0]    req_sel;
    logic             accept;
    logic             wait_to;
    logic             rsp_hs;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    assign req_sel = req_data[int'(grant_idx)*DW +: DW];
    assign accept  = (state == IDLE) && grant_any;
    assign rsp_hs  = (state == RESP) && rsp_ready[owner];

`ifdef CORE_ARB_TIMEOUT_EN
    logic [TMR_W-1:0] wait_cnt;
    logic             rsp_err_q;

    // Count WAIT cycles; cleared while issuing so each wait starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Abort fires on the TIMEOUT-th WAIT cycle; a same-cycle core_done takes precedence.
    assign wait_to = (wait_cnt == TMR_W'(TIMEOUT - 1)) && !core_done;

    // Error flag is captured together with the response payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_q <= 1'b0;
        end else if (state == WAIT && (core_done || wait_to)) begin
            rsp_err_q <= wait_to;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign wait_to = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // FSM state register; reset abandons any transaction without a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus strobes; req_ready is held low while reset is asserted.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (reset) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done || wait_to) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch owner and payload on accept; the payload stays on core_data_in until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner        <= '0;
            core_data_in <= '0;
        end else if (accept) begin
            owner        <= grant_idx;
            core_data_in <= req_sel;
        end
    end

    // Capture the core result (or zero on abort) and hold it through RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data <= '0;
        end else if (state == WAIT) begin
            if (core_done) begin
                rsp_data <= core_data_out;
            end else if (wait_to) begin
                rsp_data <= '0;
            end
        end
    end

    // Priority rotates past the owner on every completed response handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= IDX_W'(N_REQ - 1);
        end else if (rsp_hs) begin
            last_grant <= owner;
        end
    end

endmodule

// File: tb/tb_core_req_arbiter.sv
// Bench for core_req_arbiter: directed scenarios, a small core responder, and
// a transaction-level model checked against the DUT on every falling edge.
module tb_core_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
`ifdef CORE_ARB_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic [DW-1:0]   core_data_in;
    logic            core_start;
    logic            core_done;
    logic [DW-1:0]   core_data_out;

    core_req_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .core_data_in  (core_data_in),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_data_out (core_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int            m_busy, m_owner, m_age, m_res, m_err, m_last;
    logic [DW-1:0] m_cdi, m_result;
    logic [N-1:0]  e_rdy, e_rv;
    logic          e_start;
    int            g, gi, cyc;
    // Observations used by stimulus flow control and literal checks.
    logic [N-1:0]  last_ready;
    int            acc_now, start_now, rv_now, prev_rv;
    int            hs_cnt, n_start, acc_cyc, start_cyc, rsp_cyc, rv_len;
    logic [DW-1:0] first_data;
    logic [N-1:0]  first_vld;
    logic          first_err;
    int            grant_log[$];

    initial begin
        m_busy = 0; m_owner = 0; m_age = 0; m_res = 0; m_err = 0; m_last = N - 1;
        m_cdi = '0; m_result = '0; cyc = 0; last_ready = '0; acc_now = 0; start_now = 0;
        rv_now = 0; prev_rv = 0; hs_cnt = 0; n_start = 0; acc_cyc = 0; start_cyc = 0;
        rsp_cyc = 0; rv_len = 0; first_data = '0; first_vld = '0; first_err = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            m_busy = 0; m_res = 0; m_age = 0; m_last = N - 1; m_cdi = '0;
            last_ready = '0; acc_now = 0; start_now = 0; rv_now = 0; prev_rv = 0;
            chk("reset_outputs", {6'd0, req_ready, rsp_valid, core_start, rsp_err, core_data_in, rsp_data}, 32'd0);
        end else begin
            e_rdy = '0; e_rv = '0; e_start = 1'b0; g = -1;
            if (m_busy == 0) begin
                for (int k = 1; k <= N; k++) begin
                    gi = (m_last + k) % N;
                    if (g < 0 && req_valid[gi]) g = gi;
                end
                if (g >= 0) e_rdy[g] = 1'b1;
            end else if (m_age == 1) begin
                e_start = 1'b1;
            end
            if (m_busy != 0 && m_res != 0) e_rv[m_owner] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("core_start", 32'(core_start), 32'(e_start));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("core_data_in", 32'(core_data_in), 32'(m_cdi));
            if (m_busy != 0 && m_res != 0) begin
                chk("rsp_data", 32'(rsp_data), 32'(m_result));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            // observations
            last_ready = req_ready;
            acc_now    = (req_ready != 0);
            start_now  = int'(core_start);
            rv_now     = (rsp_valid != 0);
            if (req_ready != 0) begin
                acc_cyc = cyc;
                for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
            end
            if (core_start) begin n_start++; start_cyc = cyc; end
            if (rv_now != 0) begin
                if (prev_rv == 0) begin
                    rsp_cyc = cyc; rv_len = 0;
                    first_data = rsp_data; first_vld = rsp_valid; first_err = rsp_err;
                end
                rv_len++;
                if ((rsp_valid & rsp_ready) != 0) hs_cnt++;
            end
            prev_rv = rv_now;
            // advance the model across the coming edge
            if (m_busy == 0) begin
                if (g >= 0) begin
                    m_busy = 1; m_owner = g; m_age = 1; m_res = 0;
                    m_cdi = req_data[g*DW +: DW];
                end
            end else if (m_res == 0) begin
                if (m_age >= 2) begin
                    if (core_done) begin
                        m_res = 1; m_result = core_data_out; m_err = 0;
                    end
`ifdef CORE_ARB_TIMEOUT_EN
                    else if (m_age - 1 == TO) begin
                        m_res = 1; m_result = '0; m_err = 1;
                    end
`endif
                end
                m_age++;
            end else if (rsp_ready[m_owner]) begin
                m_busy = 0; m_res = 0; m_last = m_owner;
            end
        end
    end

    // ---------------- core responder ----------------
    int   auto_core = 1;
    int   core_lat  = 1;
    int   pend      = 0;
    logic spur_done = 1'b0;

    initial begin
        core_done = 1'b0;
        core_data_out = '0;
        forever begin
            @(negedge clk);
            if (core_start && auto_core != 0) pend = core_lat;
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (spur_done) begin
                core_done = 1'b1;
                core_data_out = 8'hEE;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_data_out = ~core_data_in;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int hold_req = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (hold_req == 0) req_valid = req_valid & ~last_ready;
    endtask

    task automatic wait_hs(input int target, input string nm);
        int b;
        b = 300;
        while (hs_cnt < target && b > 0) begin tick(); b--; end
        chk(nm, 32'(hs_cnt), 32'(target));
    endtask

    task automatic wait_acc(input string nm);
        int b;
        b = 50;
        while (acc_now == 0 && b > 0) begin tick(); b--; end
        chk(nm, 32'(acc_now), 32'd1);
    endtask

    task automatic wait_start(input string nm);
        int b;
        b = 50;
        while (start_now == 0 && b > 0) begin tick(); b--; end
        chk(nm, 32'(start_now), 32'd1);
    endtask

    task automatic wait_rv(input string nm);
        int b;
        b = 50;
        while (rv_now == 0 && b > 0) begin tick(); b--; end
        chk(nm, 32'(rv_now), 32'd1);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    int base, hs0, st0;

    initial begin
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        rsp_ready = 4'b1111;
        repeat (3) tick();
        chk("reset_literal", {6'd0, req_ready, rsp_valid, core_start, rsp_err, core_data_in, rsp_data}, 32'd0);
        req_valid = '0;
        reset = 1'b1;
        tick();

        // 1: single request, result three cycles after start
        core_lat = 3;
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        hs0 = hs_cnt;
        wait_hs(hs0 + 1, "t1_handshake");
        chk("t1_accept_to_start", 32'(start_cyc - acc_cyc), 32'd1);
        chk("t1_start_to_rsp", 32'(rsp_cyc - start_cyc), 32'd4);
        chk("t1_rsp_owner", 32'(first_vld), 32'h1);
        chk("t1_rsp_data", 32'(first_data), 32'hA5);

        // 2: all four requesting continuously after reset
        do_reset();
        core_lat = 1;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        base = grant_log.size();
        st0 = n_start;
        hs0 = hs_cnt;
        hold_req = 1;
        req_valid = 4'b1111;
        wait_hs(hs0 + 5, "t2_handshakes");
        req_valid = '0;
        hold_req = 0;
        chk("t2_grants", 32'(grant_log.size() - base), 32'd5);
        if (grant_log.size() >= base + 5) begin
            chk("t2_order0", 32'(grant_log[base]),     32'd0);
            chk("t2_order1", 32'(grant_log[base + 1]), 32'd1);
            chk("t2_order2", 32'(grant_log[base + 2]), 32'd2);
            chk("t2_order3", 32'(grant_log[base + 3]), 32'd3);
            chk("t2_order4", 32'(grant_log[base + 4]), 32'd0);
        end
        chk("t2_start_pulses", 32'(n_start - st0), 32'd5);

        // 3: response back-pressure with another requester waiting
        tick();
        core_lat = 2;
        rsp_ready = '0;
        hs0 = hs_cnt;
        req_valid = 4'b0100;
        wait_rv("t3_rsp_seen");
        req_valid = req_valid | 4'b0001;
        repeat (5) tick();
        rsp_ready = 4'b1111;
        wait_hs(hs0 + 1, "t3_handshake");
        chk("t3_rsp_len", 32'(rv_len), 32'd7);
        chk("t3_rsp_data", 32'(first_data), 32'hCC);
        chk("t3_rsp_owner", 32'(first_vld), 32'h4);
        wait_hs(hs0 + 2, "t3_waiter_done");
        chk("t3_waiter_grant", 32'(grant_log[grant_log.size() - 1]), 32'd0);

        // 4: asynchronous reset in WAIT, stale core_done afterwards
        tick();
        core_lat = 6;
        req_valid = 4'b0010;
        wait_start("t4_start");
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t4_async_zero", {6'd0, req_ready, rsp_valid, core_start, rsp_err, core_data_in, rsp_data}, 32'd0);
        hs0 = hs_cnt;
        req_valid = '0;
        tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("t4_no_response", 32'(hs_cnt), 32'(hs0));
        core_lat = 1;
        req_valid = 4'b0011;
        wait_acc("t4_accept");
        chk("t4_grant_after_reset", 32'(grant_log[grant_log.size() - 1]), 32'd0);
        wait_hs(hs0 + 2, "t4_handshakes");

        // 5: spurious core_done in IDLE and in ISSUE
        tick();
        hs0 = hs_cnt;
        st0 = n_start;
        spur_done = 1'b1;
        repeat (2) tick();
        spur_done = 1'b0;
        repeat (2) tick();
        chk("t5_idle_no_rsp", 32'(hs_cnt), 32'(hs0));
        chk("t5_idle_no_start", 32'(n_start), 32'(st0));
        core_lat = 2;
        req_valid = 4'b1000;
        wait_acc("t5_accept");
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        wait_hs(hs0 + 1, "t5_handshake");
        chk("t5_rsp_data", 32'(first_data), 32'hBB);

`ifdef CORE_ARB_TIMEOUT_EN
        // 6: core never answers; abort after TIMEOUT WAIT cycles
        tick();
        auto_core = 0;
        hs0 = hs_cnt;
        req_valid = 4'b0100;
        wait_hs(hs0 + 1, "t6_abort_handshake");
        chk("t6_start_to_rsp", 32'(rsp_cyc - start_cyc), 32'(TO + 1));
        chk("t6_err", 32'(first_err), 32'd1);
        chk("t6_data", 32'(first_data), 32'd0);
        auto_core = 1;
        core_lat = 1;
        req_valid = 4'b0101;
        wait_hs(hs0 + 3, "t6_after_abort");
        chk("t6_rotate", 32'(grant_log[grant_log.size() - 2]), 32'd0);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errs);
        $fatal(1);
    end

endmodule
